// File: rtl/key_pkg.sv
// Shared timing constants for the key conditioning blocks (50 MHz system clock).
package key_pkg;

  // Stable time needed before a key level is accepted (20 ms).
  localparam int KEY_DLY_20MS = 1_000_000;

  // Hold time after which a press counts as a long press (1 s).
  localparam int KEY_DLY_1S = 50_000_000;

endpackage

// File: rtl/key_debounce_multi_if.sv
// Key bundle between the key pins and the conditioned level/event outputs.
interface key_debounce_multi_if #(
  parameter int KEY_NUM = 4
);

  logic [KEY_NUM-1:0] key;
  logic [KEY_NUM-1:0] key_flt;
  logic [KEY_NUM-1:0] key_press;
  logic [KEY_NUM-1:0] key_release;
  logic [KEY_NUM-1:0] key_long;

  // The board side drives raw keys and consumes the conditioned signals.
  modport master (
    output key,
    input  key_flt,
    input  key_press,
    input  key_release,
    input  key_long
  );

  // The conditioner takes raw keys and produces the filtered level and events.
  modport slave (
    input  key,
    output key_flt,
    output key_press,
    output key_release,
    output key_long
  );

endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchroniser, reload-on-change debounce counter,
// filtered level with press/release pulses and a saturating long-press timer.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int   CNT_DLY  = KEY_DLY_20MS,
  parameter int   LONG_DLY = KEY_DLY_1S,
  parameter logic KEY_ACT  = 1'b0
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key,
  output logic key_flt,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int DW = $clog2(CNT_DLY + 1);
  localparam int HW = $clog2(LONG_DLY + 1);

  localparam logic [DW-1:0] D_LOAD = DW'(CNT_DLY);
  localparam logic [DW-1:0] D_ONE  = DW'(1);
  localparam logic [HW-1:0] H_MAX  = HW'(LONG_DLY);
  localparam logic [HW-1:0] H_PRE  = HW'(LONG_DLY - 1);
  localparam logic [HW-1:0] H_ONE  = HW'(1);

  logic          s0;
  logic          s1;
  logic          s2;
  logic [DW-1:0] dcnt;
  logic [HW-1:0] hcnt;
  logic          change;
  logic          upd;
  logic          pressed;

  assign change  = (s1 != s2);
  assign upd     = (dcnt == D_ONE);
  assign pressed = (key_flt == KEY_ACT);

  // Bring the asynchronous pin into the clock domain; s2 gives the edge reference.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s0 <= ~KEY_ACT;
      s1 <= ~KEY_ACT;
      s2 <= ~KEY_ACT;
    end else begin
      s0 <= key;
      s1 <= s0;
      s2 <= s1;
    end
  end

  // Any change restarts the stability window; otherwise count down to zero and rest.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dcnt <= '0;
    end else if (change) begin
      dcnt <= D_LOAD;
    end else if (dcnt != '0) begin
      dcnt <= dcnt - D_ONE;
    end
  end

  // Accept the stable level at the end of the window and pulse on a real level change.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_flt     <= ~KEY_ACT;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_press   <= upd && (s2 != key_flt) && (s2 == KEY_ACT);
      key_release <= upd && (s2 != key_flt) && (s2 != KEY_ACT);
      if (upd) begin
        key_flt <= s2;
      end
    end
  end

  // Time how long the filtered level stays pressed; fire once as the timer saturates.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hcnt     <= '0;
      key_long <= 1'b0;
    end else begin
      key_long <= pressed && (hcnt == H_PRE);
      if (!pressed) begin
        hcnt <= '0;
      end else if (hcnt < H_MAX) begin
        hcnt <= hcnt + H_ONE;
      end
    end
  end

endmodule

// File: rtl/key_debounce_multi.sv
// N-channel push-button conditioner: one independent key_debounce_ch per key pin.
module key_debounce_multi
  import key_pkg::*;
#(
  parameter int   KEY_NUM  = 4,
  parameter int   CNT_DLY  = KEY_DLY_20MS,
  parameter int   LONG_DLY = KEY_DLY_1S,
  parameter logic KEY_ACT  = 1'b0
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  key_debounce_multi_if.slave   key_bus
);

  // Channels share nothing but clock and reset.
  for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
    key_debounce_ch #(
      .CNT_DLY  (CNT_DLY),
      .LONG_DLY (LONG_DLY),
      .KEY_ACT  (KEY_ACT)
    ) u_ch (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .key         (key_bus.key[i]),
      .key_flt     (key_bus.key_flt[i]),
      .key_press   (key_bus.key_press[i]),
      .key_release (key_bus.key_release[i]),
      .key_long    (key_bus.key_long[i])
    );
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Self-checking bench for key_debounce_multi: directed scenarios plus random
// bouncing keys, compared against a run-length reference model of the inputs.
module tb_key_debounce_multi;

  localparam int         CNT    = 8;
  localparam int         LONG   = 20;
  localparam logic [3:0] IDLE_V = 4'hF;

  logic sys_clk;
  logic sys_rst_n;

  key_debounce_multi_if #(.KEY_NUM(4)) bus ();

  key_debounce_multi #(
    .KEY_NUM  (4),
    .CNT_DLY  (CNT),
    .LONG_DLY (LONG),
    .KEY_ACT  (1'b0)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_bus   (bus.slave)
  );

  int compare_cnt  = 0;
  int mismatch_cnt = 0;

  // Reference model state: sampled key value per edge since reset release.
  logic [3:0] hist[$];
  int         edge_n;
  logic [3:0] flt_m;
  int         press_edge[4];
  logic [3:0] exp_press;
  logic [3:0] exp_rel;
  logic [3:0] exp_long;
  int         press_cnt[4];
  int         rel_cnt[4];
  int         long_cnt[4];

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compare_cnt++;
    assert (obs === exp) else begin
      mismatch_cnt++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Key level seen at edge k; before the first edge the pins count as idle.
  function automatic logic [3:0] sample(input int k);
    if (k < 1) return IDLE_V;
    return hist[k-1];
  endfunction

  task automatic model_clear();
    hist.delete();
    edge_n = 0;
    flt_m  = IDLE_V;
    for (int c = 0; c < 4; c++) begin
      press_edge[c] = -100000;
      press_cnt[c]  = 0;
      rel_cnt[c]    = 0;
      long_cnt[c]   = 0;
    end
  endtask

  // Drive keys, take one clock edge, advance the model and compare every output.
  task automatic applyStimulus(input logic [3:0] keys);
    int   k;
    bit   upd;
    logic v;
    bus.key = keys;
    @(posedge sys_clk);
    #1;
    edge_n++;
    hist.push_back(keys);
    exp_press = '0;
    exp_rel   = '0;
    exp_long  = '0;
    k = edge_n - 3;
    for (int c = 0; c < 4; c++) begin
      exp_long[c] = (flt_m[c] == 1'b0) && ((edge_n - press_edge[c]) == LONG);
      // A level is taken when a run of exactly CNT equal samples, started by a
      // real change, ends three edges back (two sync stages plus the update).
      upd = (k - CNT >= 0);
      if (upd) begin
        v = sample(k)[c];
        if (sample(k - CNT)[c] == v) upd = 0;
        for (int j = k - CNT + 1; j <= k; j++)
          if (sample(j)[c] != v) upd = 0;
        if (upd && (v != flt_m[c])) begin
          if (v == 1'b0) begin
            exp_press[c]  = 1'b1;
            press_edge[c] = edge_n;
          end else begin
            exp_rel[c] = 1'b1;
          end
          flt_m[c] = v;
        end
      end
    end
    checkOutput("key_flt", bus.key_flt, flt_m);
    checkOutput("key_press", bus.key_press, exp_press);
    checkOutput("key_release", bus.key_release, exp_rel);
    checkOutput("key_long", bus.key_long, exp_long);
    for (int c = 0; c < 4; c++) begin
      press_cnt[c] += int'(bus.key_press[c]);
      rel_cnt[c]   += int'(bus.key_release[c]);
      long_cnt[c]  += int'(bus.key_long[c]);
    end
  endtask

  // Assert reset away from a clock edge and check that outputs clear immediately.
  task automatic applyReset(input logic [3:0] keys);
    bus.key = keys;
    #2;
    sys_rst_n = 1'b0;
    #1;
    checkOutput("rst_async_flt", bus.key_flt, IDLE_V);
    checkOutput("rst_async_press", bus.key_press, 4'h0);
    checkOutput("rst_async_release", bus.key_release, 4'h0);
    checkOutput("rst_async_long", bus.key_long, 4'h0);
    repeat (2) begin
      @(posedge sys_clk);
      #1;
      checkOutput("rst_hold_flt", bus.key_flt, IDLE_V);
      checkOutput("rst_hold_events", {bus.key_press, bus.key_release, bus.key_long}, 12'h0);
    end
    model_clear();
    sys_rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] k;
    logic [3:0] lvl;
    int         rem[4];

    $display("[TB] start");
    sys_rst_n = 1'b1;
    bus.key   = IDLE_V;
    model_clear();
    @(posedge sys_clk);
    #1;

    // Reset with all keys idle, then the directed multi-channel scenario.
    applyReset(IDLE_V);
    for (int n = 1; n <= 120; n++) begin
      k[0] = 1'b0;
      k[1] = !((n >= 1 && n <= 5) || (n >= 9 && n <= 12));
      k[2] = !(n <= 40);
      k[3] = !(n >= 60 && n <= 74);
      applyStimulus(k);
      if (n == 10) checkOutput("ch0_press_E10", bus.key_press[0], 1'b0);
      if (n == 11) begin
        checkOutput("ch0_flt_E11", bus.key_flt[0], 1'b0);
        checkOutput("ch0_press_E11", bus.key_press[0], 1'b1);
        checkOutput("ch2_press_E11", bus.key_press[2], 1'b1);
        checkOutput("ch13_flt_E11", {bus.key_flt[3], bus.key_flt[1]}, 2'b11);
      end
      if (n == 12) checkOutput("ch0_press_E12", bus.key_press[0], 1'b0);
      if (n == 31) checkOutput("ch02_long_E31", {bus.key_long[2], bus.key_long[0]}, 2'b11);
      if (n == 51) checkOutput("ch2_release_E51", bus.key_release[2], 1'b1);
      if (n == 70) checkOutput("ch3_press_E70", bus.key_press[3], 1'b1);
      if (n == 85) checkOutput("ch3_release_E85", bus.key_release[3], 1'b1);
      if (n > 13) checkOutput("ch1_flt_hold", bus.key_flt[1], 1'b1);
    end
    checkOutput("ch1_press_count", press_cnt[1], 0);
    checkOutput("ch1_release_count", rel_cnt[1], 0);
    checkOutput("ch2_long_count", long_cnt[2], 1);
    checkOutput("ch3_long_count", long_cnt[3], 0);
    checkOutput("ch0_long_count", long_cnt[0], 1);
    checkOutput("ch0_press_count", press_cnt[0], 1);

    // Hold key 0, reset once its long-press timer has reached 10, keep holding.
    applyReset(IDLE_V);
    for (int n = 1; n <= 21; n++) applyStimulus(4'hE);
    checkOutput("ch0_flt_before_rst", bus.key_flt[0], 1'b0);
    applyReset(4'hE);
    for (int n = 1; n <= 30; n++) begin
      applyStimulus(4'hE);
      if (n == 10) checkOutput("ch0_press_after_rst_E10", bus.key_press[0], 1'b0);
      if (n == 11) checkOutput("ch0_press_after_rst_E11", bus.key_press[0], 1'b1);
    end

    // Random bouncing and holding on every channel, checked against the model.
    applyReset(IDLE_V);
    lvl = IDLE_V;
    for (int c = 0; c < 4; c++) rem[c] = int'($urandom_range(1, 30));
    for (int n = 1; n <= 600; n++) begin
      for (int c = 0; c < 4; c++) begin
        rem[c]--;
        if (rem[c] <= 0) begin
          lvl[c] = ~lvl[c];
          rem[c] = int'($urandom_range(1, 30));
        end
      end
      applyStimulus(lvl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
    $finish;
  end

endmodule
